// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared definitions for the instruction fetch unit: instruction
//            width, fetch FSM state encoding and an alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam int unsigned c_instr_w = 32;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [c_instr_w-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_fifo
// Purpose  : Small synchronous FIFO with flush. The head entry is read
//            straight from storage, so data pushed in cycle N is visible at
//            the head in cycle N+1 (no write-to-read bypass).
// Ports    : clk       - clock, all state on rising edge
//            rst_n     - asynchronous active-low reset (clears storage too)
//            flush     - empties the FIFO; wins over push and pop
//            push      - write push_data (ignored when full and not popping)
//            push_data - entry to write
//            pop       - discard head entry (ignored when empty)
//            head_data - oldest entry
//            empty     - no entries held
//            full      - DEPTH entries held
//            count     - number of entries held
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(DEPTH - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign empty     = (r_count == '0);
  assign full      = (r_count == CNT_W'(DEPTH));
  assign count     = r_count;
  assign head_data = r_mem[r_rd_ptr];

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_do_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifetch.sv
`default_nettype none
// ============================================================================
// Module   : ifetch
// Purpose  : Instruction fetch unit sitting between control and instruction
//            memory. Issues sequential word fetches under a credit limit,
//            tracks in-flight requests, buffers responses with their PC and
//            hands them to control. A redirect flushes the buffer and drops
//            responses still in flight; a misaligned redirect target locks
//            the unit in FAULT until reset.
// Ports    : sysclk             - clock
//            nrst_in            - asynchronous active-low reset
//            imem_req_valid_out - fetch request valid
//            imem_req_ready_in  - memory accepts request
//            imem_req_addr_out  - word-aligned fetch address
//            imem_rsp_valid_in  - response valid (in request order)
//            imem_rsp_data_in   - fetched instruction word
//            instr_valid_out    - instruction available to control
//            instr_ready_in     - control consumes instruction
//            instr_out          - instruction word
//            instr_pc_out       - address of instr_out
//            redirect_in        - taken branch/jump: flush and refetch
//            redirect_pc_in     - new fetch address
//            fault_out          - misaligned redirect seen (sticky)
// Revision : 1.0 - initial release
// ============================================================================
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        sysclk,
  input  logic        nrst_in,
  output logic        imem_req_valid_out,
  input  logic        imem_req_ready_in,
  output logic [31:0] imem_req_addr_out,
  input  logic        imem_rsp_valid_in,
  input  logic [31:0] imem_rsp_data_in,
  output logic        instr_valid_out,
  input  logic        instr_ready_in,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        fault_out
);

  localparam int unsigned      c_cnt_w   = $clog2(DEPTH + 1);
  localparam int unsigned      c_entry_w = 2 * c_instr_w;
  localparam logic [c_cnt_w:0] c_credits = (c_cnt_w + 1)'(DEPTH);

  fetch_state_e         r_state;
  fetch_state_e         w_state_next;
  logic                 r_req_en;
  logic [c_instr_w-1:0] r_fetch_pc;
  logic [c_cnt_w-1:0]   r_outstanding;
  logic [c_cnt_w-1:0]   r_drop_count;

  logic                 w_in_run;
  logic                 w_req_fire;
  logic                 w_rsp_seen;
  logic                 w_rsp_keep;
  logic                 w_instr_fire;
  logic [c_cnt_w:0]     w_credit_used;
  logic [c_instr_w-1:0] w_rsp_pc;
  logic [c_entry_w-1:0] w_head_entry;
  logic                 w_instr_empty;
  logic                 w_instr_full;
  logic [c_cnt_w-1:0]   w_instr_count;
  logic                 w_pc_empty;
  logic                 w_pc_full;
  logic [c_cnt_w-1:0]   w_pc_count;
  logic                 w_unused_status;

  // --------------------------------------------------------------------------
  // Request side
  // --------------------------------------------------------------------------
  // Dropped-pending responses still count as outstanding, so the credit
  // check below also guarantees the buffer can never be pushed when full.
  assign w_credit_used     = {1'b0, r_outstanding} + {1'b0, w_instr_count};
  assign imem_req_addr_out = {r_fetch_pc[31:2], 2'b00};
  assign w_req_fire        = imem_req_valid_out && imem_req_ready_in;

  // A response only belongs to a live request when nothing is being dropped,
  // no redirect is flushing this cycle and the unit has not faulted.
  assign w_rsp_seen = imem_rsp_valid_in && (r_outstanding != '0);
  assign w_rsp_keep = w_rsp_seen && w_in_run && !redirect_in && (r_drop_count == '0);

  // --------------------------------------------------------------------------
  // FSM: state register and next-state/output logic
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_in_run           = 1'b0;
    imem_req_valid_out = 1'b0;
    fault_out          = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_in_run = 1'b1;
        // r_req_en keeps the request low while reset is asserted and rises
        // on the first clock edge after release.
        imem_req_valid_out = r_req_en && !redirect_in && (w_credit_used < c_credits);
        if (redirect_in && !is_word_aligned(redirect_pc_in)) begin
          w_state_next = ST_FAULT;
        end
      end
      ST_FAULT: begin
        fault_out = 1'b1;
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch PC, in-flight and drop bookkeeping
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge nrst_in) begin
    if (!nrst_in) begin
      r_req_en      <= 1'b0;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_count  <= '0;
    end else begin
      r_req_en <= 1'b1;

      if (redirect_in && w_in_run) begin
        r_fetch_pc <= redirect_pc_in;
      end else if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end

      case ({w_req_fire, w_rsp_seen})
        2'b10:   r_outstanding <= r_outstanding + c_cnt_w'(1);
        2'b01:   r_outstanding <= r_outstanding - c_cnt_w'(1);
        default: r_outstanding <= r_outstanding;
      endcase

      // Everything in flight at a redirect is stale; a response arriving in
      // the redirect cycle itself is already discarded, so it is excluded.
      if (redirect_in) begin
        r_drop_count <= r_outstanding - c_cnt_w'(w_rsp_seen);
      end else if (w_rsp_seen && (r_drop_count != '0)) begin
        r_drop_count <= r_drop_count - c_cnt_w'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // PC of each live request, pushed at accept and popped by its response
  // --------------------------------------------------------------------------
  ifetch_fifo #(
    .WIDTH (c_instr_w),
    .DEPTH (DEPTH)
  ) u_pc_fifo (
    .clk       (sysclk),
    .rst_n     (nrst_in),
    .flush     (redirect_in),
    .push      (w_req_fire),
    .push_data (imem_req_addr_out),
    .pop       (w_rsp_keep),
    .head_data (w_rsp_pc),
    .empty     (w_pc_empty),
    .full      (w_pc_full),
    .count     (w_pc_count)
  );

  // --------------------------------------------------------------------------
  // Delivered {pc, instr} buffer toward control
  // --------------------------------------------------------------------------
  assign w_instr_fire = instr_valid_out && instr_ready_in;

  ifetch_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (sysclk),
    .rst_n     (nrst_in),
    .flush     (redirect_in),
    .push      (w_rsp_keep),
    .push_data ({w_rsp_pc, imem_rsp_data_in}),
    .pop       (w_instr_fire),
    .head_data (w_head_entry),
    .empty     (w_instr_empty),
    .full      (w_instr_full),
    .count     (w_instr_count)
  );

  assign instr_valid_out = w_in_run && !w_instr_empty;
  assign instr_pc_out    = w_head_entry[c_entry_w-1:c_instr_w];
  assign instr_out       = w_head_entry[c_instr_w-1:0];

  assign w_unused_status = w_pc_empty ^ w_pc_full ^ w_instr_full ^ (^w_pc_count);

endmodule
`default_nettype wire
